// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/read/exec/writeback control FSM
module cpu_sequencer #(
   parameter int              PC_W     = 4,
   parameter int              PROG_LEN = 16,
   parameter int              OP_W     = 3,
   parameter logic [OP_W-1:0] HALT_OP  = {OP_W{1'b1}},
   parameter int              CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic             exec_done,
   output logic [PC_W-1:0]  pc,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             read_en,
   output logic             exec_en,
   output logic             wb_en,
   output logic             busy,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_READ   = 3'd3,
      S_EXEC   = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PROG_LEN - 1);
   localparam logic [CNT_W-1:0] RET_MAX = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             fetch_en_q, fetch_en_d;
   logic             decode_en_q, decode_en_d;
   logic             read_en_q, read_en_d;
   logic             exec_en_q, exec_en_d;
   logic             wb_en_q, wb_en_d;
   logic             busy_q, busy_d;
   logic             halted_q, halted_d;

   // Next state, pc and retire count; outputs are decoded from the next state so they register in step with it
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      retired_d = retired_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            state_d = S_DECODE;
         end
         S_DECODE: begin
            state_d = (op == HALT_OP) ? S_HALT : S_READ;
         end
         S_READ: begin
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (exec_done) state_d = S_WB;
         end
         S_WB: begin
            state_d = S_FETCH;
            pc_d    = (pc_q == PC_LAST) ? '0 : pc_q + PC_W'(1);
            if (retired_q != RET_MAX) retired_d = retired_q + CNT_W'(1);
         end
         S_HALT: begin
            if (start) begin
               state_d = S_FETCH;
               pc_d    = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      fetch_en_d  = (state_d == S_FETCH);
      decode_en_d = (state_d == S_DECODE);
      read_en_d   = (state_d == S_READ);
      exec_en_d   = (state_d == S_EXEC);
      wb_en_d     = (state_d == S_WB);
      halted_d    = (state_d == S_HALT);
      busy_d      = (state_d != S_IDLE) && (state_d != S_HALT);
   end

   // State and registered outputs; reset clears everything at once so no writeback can complete
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         retired_q   <= '0;
         fetch_en_q  <= 1'b0;
         decode_en_q <= 1'b0;
         read_en_q   <= 1'b0;
         exec_en_q   <= 1'b0;
         wb_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         retired_q   <= retired_d;
         fetch_en_q  <= fetch_en_d;
         decode_en_q <= decode_en_d;
         read_en_q   <= read_en_d;
         exec_en_q   <= exec_en_d;
         wb_en_q     <= wb_en_d;
         busy_q      <= busy_d;
         halted_q    <= halted_d;
      end
   end

   assign pc        = pc_q;
   assign retired   = retired_q;
   assign fetch_en  = fetch_en_q;
   assign decode_en = decode_en_q;
   assign read_en   = read_en_q;
   assign exec_en   = exec_en_q;
   assign wb_en     = wb_en_q;
   assign busy      = busy_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - randomized self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

   localparam int         PC_W     = 4;
   localparam int         PROG_LEN = 12;
   localparam int         CNT_W    = 8;
   localparam int         RET_MAX  = 255;
   localparam logic [2:0] HALT     = 3'b111;

   // expected {fetch_en, decode_en, read_en, exec_en, wb_en, busy, halted}
   localparam logic [6:0] V_IDLE  = 7'b0000000;
   localparam logic [6:0] V_FETCH = 7'b1000010;
   localparam logic [6:0] V_DEC   = 7'b0100010;
   localparam logic [6:0] V_READ  = 7'b0010010;
   localparam logic [6:0] V_EXEC  = 7'b0001010;
   localparam logic [6:0] V_WB    = 7'b0000110;
   localparam logic [6:0] V_HALT  = 7'b0000001;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [2:0]       op;
   logic             exec_done;
   logic [PC_W-1:0]  pc;
   logic             fetch_en, decode_en, read_en, exec_en, wb_en, busy, halted;
   logic [CNT_W-1:0] retired;

   int total = 0;
   int bad   = 0;
   int exp_pc;
   int exp_ret;
   bit in_halt;

   cpu_sequencer #(
      .PC_W(PC_W), .PROG_LEN(PROG_LEN), .OP_W(3), .HALT_OP(HALT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .exec_done(exec_done),
      .pc(pc), .fetch_en(fetch_en), .decode_en(decode_en), .read_en(read_en),
      .exec_en(exec_en), .wb_en(wb_en), .busy(busy), .halted(halted), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic outs(input string tag, input logic [6:0] expv);
      check({tag, "_ctl"}, {25'd0, fetch_en, decode_en, read_en, exec_en, wb_en, busy, halted}, {25'd0, expv});
      check({tag, "_pc"}, {28'd0, pc}, exp_pc);
      check({tag, "_retired"}, {24'd0, retired}, exp_ret);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One instruction: entered at a negedge just before FETCH begins, left at the negedge inside WB
   // (or inside HALT for the halt opcode). k is the number of EXEC cycles with exec_done low.
   task automatic do_instr(input logic [2:0] op_v, input int k);
      if (in_halt) exp_pc = 0;
      in_halt   = 1'b0;
      start     = 1'b1;
      op        = op_v;
      exec_done = 1'($urandom);
      step();
      outs("fetch", V_FETCH);
      start     = 1'($urandom);
      exec_done = 1'($urandom);
      step();
      outs("decode", V_DEC);
      if (op_v == HALT) begin
         start     = 1'b0;
         exec_done = 1'($urandom);
         step();
         outs("halt", V_HALT);
         exec_done = 1'($urandom);
         step();
         outs("halt_hold", V_HALT);
         in_halt = 1'b1;
         return;
      end
      exec_done = 1'($urandom);
      step();
      outs("read", V_READ);
      step();
      for (int i = 0; i <= k; i++) begin
         outs("exec", V_EXEC);
         exec_done = (i == k);
         start     = 1'($urandom);
         step();
      end
      outs("wb", V_WB);
      exp_pc    = (exp_pc + 1) % PROG_LEN;
      exp_ret   = (exp_ret < RET_MAX) ? exp_ret + 1 : RET_MAX;
      start     = 1'b0;
      exec_done = 1'($urandom);
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      exec_done = 1'b0;
      op        = 3'b000;
      exp_pc    = 0;
      exp_ret   = 0;
      in_halt   = 1'b0;
      #1;
      outs("reset", V_IDLE);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // stray exec_done while idle must not start anything
      repeat (3) begin
         exec_done = 1'($urandom);
         step();
         outs("idle", V_IDLE);
      end

      // minimum-latency instruction, then one with three stalled EXEC cycles
      do_instr(3'b000, 0);
      do_instr(3'b010, 3);

      // walk to pc=5 and halt there, then restart from pc 0
      while (exp_pc != 5) do_instr(3'($urandom_range(0, 6)), $urandom_range(0, 2));
      do_instr(HALT, 0);
      do_instr(3'b001, 0);

      // random opcode / stall mix, including halts and pc wrap
      repeat (40) do_instr(3'($urandom_range(0, 7)), $urandom_range(0, 3));

      // asynchronous reset in the middle of a WB cycle
      do_instr(3'b011, 1);
      #2 reset = 1'b1;
      #1;
      exp_pc  = 0;
      exp_ret = 0;
      in_halt = 1'b0;
      outs("async_reset", V_IDLE);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         exec_done = 1'($urandom);
         step();
         outs("post_reset_idle", V_IDLE);
      end

      // drive retired past its maximum
      repeat (262) do_instr(3'($urandom_range(0, 6)), 0);
      check("retired_saturated", {24'd0, retired}, RET_MAX);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
